pipe_out_fifo: RTL and testbench
================================

# pipe_out_fifo

- Terminal buffer of the stalled-pipeline datapath.
- Captures the result word leaving the last pipeline stage and queues it for a downstream consumer.
- Generates `fifo_out_ready`, the global advance enable consumed by the valid chain and all pipeline stage registers.
- A full buffer freezes the whole pipeline; nothing is dropped.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of the pipeline result word.
- `DEPTH`, 8: number of entries. Must be a power of two, ≥ 2.
- `PTR_W`, `$clog2(DEPTH)`: derived pointer width. Not to be overridden.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: valid bit of the last pipeline stage (`valid_out[STAGE_COUNT-1]`).
- `in_data`  in  DATA_WIDTH: result word of the last pipeline stage.
- `fifo_out_ready`  out  1: pipeline advance enable. High means the FIFO is not full.
- `out_valid`  out  1: FIFO holds at least one word.
- `out_data`  out  DATA_WIDTH: head-of-queue word.
- `out_ready`  in  1: consumer accepts the head word this cycle.
- `level`  out  PTR_W+1: current occupancy, 0..DEPTH.

## Operation
- Write: `wr = in_valid & fifo_out_ready`.
  - On the edge, store `in_data` at `wr_ptr` and increment `wr_ptr`.
  - This is the same edge on which the pipeline advances, so the last-stage word is captured exactly once.
- Read: `rd = out_valid & out_ready`.
  - On the edge, increment `rd_ptr`.
- Pointers are PTR_W bits wide and wrap modulo DEPTH (DEPTH-1 → 0).
- `level` register update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both or neither.
- `fifo_out_ready = (level != DEPTH)`.
  - Decoded from registered state only.
  - No combinational path from `out_ready` or `in_valid`.
- `out_valid = (level != 0)`.
- `out_data = mem[rd_ptr]`, combinational read. Don't-care while `out_valid` is low.
- Full with `out_ready` high: the read completes, but no write is possible that cycle because `fifo_out_ready` is already low. `fifo_out_ready` rises the next cycle.
- Empty with `in_valid` high: the write completes. The word appears on `out_data` with `out_valid` high the next cycle. There is no fall-through in the write cycle.
- Simultaneous read and write, 0 < level < DEPTH: both pointers advance and `level` is unchanged.
- `in_valid` low with `fifo_out_ready` high: a pipeline bubble. Nothing is stored and the pointers hold.
- Write attempt while full: impossible by construction. The bench asserts it never happens.
- Read while empty: ignored, because `out_valid` is low.

## Timing
- Reset assertion (`reset` low) takes effect immediately, without waiting for `clk`:
  - `wr_ptr`, `rd_ptr` and `level` = 0.
  - Therefore `fifo_out_ready` = 1 and `out_valid` = 0.
  - `mem` is not reset.
- Reset deassertion is synchronised externally. The first write may occur on the first rising edge after release.
- Reset mid-operation discards all queued words. There is no partial-state recovery.
- Write-to-read latency: 1 cycle. A word written at edge N is visible on `out_data` after edge N, readable at edge N+1.
- Backpressure latency: `fifo_out_ready` falls on the edge where `level` reaches DEPTH. The stall applies to the pipeline's next edge. No entry beyond DEPTH is needed.
- Sustained throughput is 1 word/cycle when `out_ready` is held high and the pipeline is streaming.

## Configuration
- Macro: `PIPE_OUT_FIFO_HWM_EN`.
- Defined:
  - Adds output `hwm` (PTR_W+1 bits), holding the maximum `level` reached since reset.
  - `hwm` updates on the edge after `level` exceeds it.
  - `hwm` is cleared to 0 by `reset`.
  - Adds output `stall_cnt` (16 bits, saturating at 0xFFFF), counting cycles with `in_valid & ~fifo_out_ready`.
- Undefined: neither port exists and no related logic is synthesised. All other behaviour is identical.

## Test plan
- Reset then idle, `out_ready` = 0:
  - `fifo_out_ready` = 1, `out_valid` = 0, `level` = 0.
  - Assert `reset` low mid-cycle → the same values appear immediately, without a clock edge.
- Fill, DEPTH = 8, `out_ready` = 0: stream words 0x01..0x08, then hold 0x09.
  - `level` reaches 8 and `fifo_out_ready` drops on that same edge.
  - 0x09 is not written and `level` stays 8.
- Drain from full: raise `out_ready` for 8 cycles.
  - `out_data` sequence is 0x01..0x08.
  - `fifo_out_ready` = 1 the cycle after the first read.
  - `out_valid` = 0 after the 8th read.
- Wrap with concurrent traffic, DEPTH = 8:
  - Stream 20 words with `out_ready` = 1 and `in_valid` toggling 1,1,0.
  - All words come out in order with no duplicates, `level` ≤ 1, and pointers wrap twice.
- Full with simultaneous read:
  - At `level` = 8 with `in_valid` = 1 and `out_ready` = 1, `level` becomes 7.
  - The next edge writes the held word, giving `level` = 8, and the output order is preserved.
- With `PIPE_OUT_FIFO_HWM_EN`:
  - Fill to 5, drain to 0 → `hwm` = 5.
  - Hold full with `in_valid` = 1 for 10 cycles → `stall_cnt` = 10.

Source files
------------

// File: rtl/pipe_out_fifo.sv
// pipe_out_fifo: terminal buffer of the stalled pipeline; queues last-stage results and generates the global advance enable
// Optional feature macro: PIPE_OUT_FIFO_HWM_EN (adds hwm and stall_cnt outputs)
// Ports:
//   clk            - single clock, rising edge
//   reset          - asynchronous active-low reset
//   in_valid       - valid bit of the last pipeline stage
//   in_data        - result word of the last pipeline stage
//   fifo_out_ready - pipeline advance enable, high while not full
//   out_valid      - at least one word queued
//   out_data       - head-of-queue word
//   out_ready      - consumer accepts the head word this cycle
//   level          - current occupancy, 0..DEPTH
//   hwm            - (HWM_EN only) maximum level since reset
//   stall_cnt      - (HWM_EN only) saturating count of stalled cycles
module pipe_out_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  fifo_out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
`ifdef PIPE_OUT_FIFO_HWM_EN
    output logic [PTR_W:0]        hwm,
    output logic [15:0]           stall_cnt,
`endif
    output logic [PTR_W:0]        level
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr;
    logic                  rd;

    // Ready and valid decode from the registered level only, so the
    // pipeline enable never depends combinationally on the consumer.
    assign fifo_out_ready = level != FULL;
    assign out_valid      = level != '0;
    assign out_data       = mem[rd_ptr];
    assign wr             = in_valid & fifo_out_ready;
    assign rd             = out_valid & out_ready;

    always_ff @(posedge clk)
        if (wr)
            mem[wr_ptr] <= in_data;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr & ~rd)
                level <= level + 1'b1;
            else if (rd & ~wr)
                level <= level - 1'b1;
        end

`ifdef PIPE_OUT_FIFO_HWM_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            hwm       <= '0;
            stall_cnt <= '0;
        end else begin
            if (level > hwm)
                hwm <= level;
            if (in_valid & ~fifo_out_ready & ~&stall_cnt)
                stall_cnt <= stall_cnt + 1'b1;
        end
`endif
endmodule

// File: tb/tb_pipe_out_fifo.sv
// tb_pipe_out_fifo: directed and randomized checks of pipe_out_fifo against a queue model
module tb_pipe_out_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int PW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          fifo_out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [PW:0]   level;
`ifdef PIPE_OUT_FIFO_HWM_EN
    logic [PW:0]   hwm;
    logic [15:0]   stall_cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] q[$];
    int max_level = 0;

    always #5 clk = ~clk;

    pipe_out_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .fifo_out_ready(fifo_out_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
`ifdef PIPE_OUT_FIFO_HWM_EN
        .hwm(hwm),
        .stall_cnt(stall_cnt),
`endif
        .level(level)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".level"}, 64'(level), 64'(q.size()));
        chk({tag, ".ready"}, 64'(fifo_out_ready), 64'(q.size() != DEPTH));
        chk({tag, ".valid"}, 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0)
            chk({tag, ".head"}, 64'(out_data), 64'(q[0]));
    endtask

    // One clock: drive inputs, predict from the queue, advance, compare.
    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d, input logic r);
        logic w, rr;
        logic [DW-1:0] head;
        in_valid = v;
        in_data = d;
        out_ready = r;
        w = v && q.size() != DEPTH;
        rr = r && q.size() != 0;
        if (rr) begin
            head = q.pop_front();
            chk({tag, ".rd_data"}, 64'(out_data), 64'(head));
        end
        @(posedge clk);
        #1;
        if (w)
            q.push_back(d);
        if (q.size() > max_level)
            max_level = q.size();
        chk_state(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        q.delete();
        max_level = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        do_reset();
        chk_state("reset");
        repeat (2) cycle("idle", 1'b0, 32'hdead, 1'b0);

        for (int i = 1; i <= 8; i++)
            cycle("fill", 1'b1, DW'(i), 1'b0);
        chk("fill.full_level", 64'(level), 64'(DEPTH));
        chk("fill.full_ready", 64'(fifo_out_ready), 64'(0));
        repeat (2) cycle("hold9", 1'b1, 32'h09, 1'b0);

        cycle("full_rd", 1'b1, 32'h09, 1'b1);
        chk("full_rd.level7", 64'(level), 64'(7));
        cycle("full_wr", 1'b1, 32'h09, 1'b0);
        chk("full_wr.level8", 64'(level), 64'(8));

        for (int i = 0; i < 8; i++) begin
            cycle("drain", 1'b0, 32'h0, 1'b1);
            if (i == 0)
                chk("drain.ready_after_first", 64'(fifo_out_ready), 64'(1));
        end
        chk("drain.valid_after_8", 64'(out_valid), 64'(0));
        cycle("drain_tail", 1'b0, 32'h0, 1'b1);
        chk("drain.empty", 64'(level), 64'(0));

        for (int i = 0; i < 3; i++)
            cycle("prefill", 1'b1, $urandom, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        chk_state("async_reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 30; i++) begin
            cycle("wrap", (i % 3) != 2, 32'h100 + DW'(i), 1'b1);
            chk("wrap.level_le1", 64'(level <= 1), 64'(1));
        end

        for (int i = 0; i < 400; i++) begin
            int bias = (i / 100) % 4;
            logic v = ($urandom_range(0, 3) >= bias[1:0]);
            logic r = ($urandom_range(0, 3) < 3 - bias[1:0]) || bias == 3 && i % 7 == 0;
            cycle("rand", v, $urandom, r);
        end

`ifdef PIPE_OUT_FIFO_HWM_EN
        do_reset();
        chk("hwm.reset", 64'(hwm), 64'(0));
        chk("stall.reset", 64'(stall_cnt), 64'(0));
        for (int i = 0; i < 5; i++)
            cycle("hwm_fill", 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 6; i++)
            cycle("hwm_drain", 1'b0, 32'h0, 1'b1);
        chk("hwm.five", 64'(hwm), 64'(5));
        for (int i = 0; i < 8; i++)
            cycle("stall_fill", 1'b1, $urandom, 1'b0);
        chk("stall.zero", 64'(stall_cnt), 64'(0));
        for (int i = 0; i < 10; i++)
            cycle("stall_hold", 1'b1, 32'h77, 1'b0);
        chk("stall.ten", 64'(stall_cnt), 64'(10));
        chk("hwm.eight", 64'(hwm), 64'(max_level));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
